// File: rtl/mux_arb_pkg.sv
// Shared sizes and FSM state encoding for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data bus between requesters, the arbiter and the downstream sink.
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int unsigned DW = 8
) ();

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] data_in;
    logic                out_ready;
    logic [N_REQ-1:0]    gnt;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [SEL_W-1:0]    out_src;

    // Requester/sink side: drives requests, data and ready.
    modport master (
        output req,
        output data_in,
        output out_ready,
        input  gnt,
        input  out_valid,
        input  out_data,
        input  out_src
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  data_in,
        input  out_ready,
        output gnt,
        output out_valid,
        output out_data,
        output out_src
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin winner search starting at ptr.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_raw,
    output logic [SEL_W-1:0] w,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // First requester found walking ptr, ptr+1, ... (mod N_REQ) wins.
    always_comb begin
        any     = 1'b0;
        w       = '0;
        idx     = '0;
        gnt_raw = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!any && req[idx]) begin
                any = 1'b1;
                w   = idx;
            end
        end
        if (any) begin
            gnt_raw = N_REQ'(1) << w;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter muxing one requester word per capture into
// a registered valid/ready output stage.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [N_REQ-1:0] gnt_raw;
    logic [SEL_W-1:0] w;
    logic             any;
    logic             capture_c;
    logic [DW-1:0]    sel_data;

    rr_pick u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .gnt_raw (gnt_raw),
        .w       (w),
        .any     (any)
    );

    // Winner index selects one of the four data slices.
    always_comb begin
        sel_data = '0;
        case (w)
            2'd0:    sel_data = bus.data_in[0*DW +: DW];
            2'd1:    sel_data = bus.data_in[1*DW +: DW];
            2'd2:    sel_data = bus.data_in[2*DW +: DW];
            default: sel_data = bus.data_in[3*DW +: DW];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and capture decision; a capture frees the output slot.
    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    capture_c = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.out_ready) begin
                    if (any) begin
                        capture_c = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant pulse for the word being captured; suppressed while in reset.
    always_comb begin
        bus.gnt = '0;
        if (capture_c && rst_n) begin
            bus.gnt = gnt_raw;
        end
    end

    // Output stage and round-robin pointer; previous winner drops to lowest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            ptr           <= '0;
        end else begin
            bus.out_valid <= (state_nxt == BUSY);
            if (capture_c) begin
                bus.out_data <= sel_data;
                bus.out_src  <= w;
                ptr          <= w + SEL_W'(1);
            end
        end
    end

endmodule
